// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: WIDTH-bit operation in WIDTH/DIGIT steps, LSB digit first.
// Define SERIAL_ADDSUB_OVF_EN to enable signed-overflow output; otherwise ovf is tied to 0.
module serial_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             load, step, last;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] acc_nxt;

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // New digit enters at the MSB end; after N steps the first digit sits at bit 0.
        acc_nxt = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_nxt;
            carry_q <= slice[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= slice[DIGIT];
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the last step the low slices of a_q/b_q hold the original operand MSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (step && last) begin
            ovf <= (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice[DIGIT-1] != a_q[DIGIT-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: 16/4 and 8/8 configurations.
// Expected ovf follows SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, sub16, start8, sub8;
    logic [15:0] a16, b16, sum16;
    logic [7:0]  a8, b8, sum8;
    logic        ready16, busy16, done16, cout16, ovf16;
    logic        ready8, busy8, done8, cout8, ovf8;

    logic        sel8;
    logic        r_ready, r_busy, r_done, r_cout, r_ovf;
    logic [15:0] r_sum;
    logic [15:0] last_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    always_comb begin
        r_ready = sel8 ? ready8 : ready16;
        r_busy  = sel8 ? busy8  : busy16;
        r_done  = sel8 ? done8  : done16;
        r_cout  = sel8 ? cout8  : cout16;
        r_ovf   = sel8 ? ovf8   : ovf16;
        r_sum   = sel8 ? {8'h00, sum8} : sum16;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic s, input logic [15:0] x, input logic [15:0] y);
        if (sel8) begin
            start8 = st; sub8 = s; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start16 = st; sub16 = s; a16 = x; b16 = y;
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && r_ready !== 1'b1; i++) @(negedge clk);
        check({tag, "_ready_wait"}, r_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, r_ready, 1);
        check({tag, "_busy"},  r_busy,  0);
        check({tag, "_done"},  r_done,  0);
        check({tag, "_sum"},   r_sum,   0);
        check({tag, "_cout"},  r_cout,  0);
        check({tag, "_ovf"},   r_ovf,   0);
    endtask

    task automatic op(input logic s, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] es, input logic ec, input logic eo, input string tag);
        int n;
        n = sel8 ? 1 : 4;
        wait_ready(tag);
        drive(1'b1, s, x, y);
        @(negedge clk);
        drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < n; i++) begin
            check({tag, "_run_busy"},  r_busy,  1);
            check({tag, "_run_done"},  r_done,  0);
            check({tag, "_run_ready"}, r_ready, 0);
            check({tag, "_run_sum_hold"}, r_sum, last_sum);
            @(negedge clk);
        end
        check({tag, "_done"}, r_done, 1);
        check({tag, "_done_busy"}, r_busy, 0);
        check({tag, "_sum"},  r_sum,  es);
        check({tag, "_cout"}, r_cout, ec);
        check({tag, "_ovf"},  r_ovf,  eo);
        last_sum = es;
        @(negedge clk);
        check({tag, "_after_done"},  r_done,  0);
        check({tag, "_after_ready"}, r_ready, 1);
        check({tag, "_after_sum"},   r_sum,   es);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1;
        sel8 = 1'b0;
        last_sum = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; sub8  = 1'b0; a8  = '0; b8  = '0;

        @(negedge clk);
        check_reset_outputs("rst16");
        sel8 = 1'b1;
        #1 check_reset_outputs("rst8");
        sel8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0,   "add_1234_0fff");
        op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0,   "add_ffff_0001");
        op(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0,   "sub_0005_0007");
        op(1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0,   "sub_0007_0005");
        op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, OVF_ON, "add_7fff_0001");
        op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, OVF_ON, "sub_8000_0001");

        // start pulses during RUN and DONE must be ignored
        wait_ready("ign");
        drive(1'b1, 1'b0, 16'h0100, 16'h0200);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("ign_run_busy2", r_busy, 1);
        @(negedge clk);
        check("ign_run_busy3", r_busy, 1);
        @(negedge clk);
        check("ign_done", r_done, 1);
        check("ign_sum",  r_sum,  16'h0300);
        check("ign_cout", r_cout, 0);
        check("ign_ovf",  r_ovf,  0);
        drive(1'b1, 1'b0, 16'h4444, 16'h4444);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("ign_after_ready", r_ready, 1);
        check("ign_after_busy",  r_busy,  0);
        @(negedge clk);
        check("ign_idle_ready", r_ready, 1);
        check("ign_idle_busy",  r_busy,  0);
        check("ign_idle_sum",   r_sum,   16'h0300);
        last_sum = 16'h0300;

        // asynchronous reset two cycles into RUN
        wait_ready("rstrun");
        drive(1'b1, 1'b0, 16'h1111, 16'h2222);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("rstrun_busy_before", r_busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rstrun_async");
        last_sum = '0;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (r_done === 1'b1) done_seen++;
        end
        check("rstrun_no_done", done_seen, 0);
        check("rstrun_idle_busy", r_busy, 0);
        op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "add_after_rst");

        // WIDTH=8, DIGIT=8 instance: single RUN cycle
        sel8 = 1'b1;
        last_sum = '0;
        #1;
        op(1'b0, 16'h0080, 16'h0080, 16'h0000, 1'b1, OVF_ON, "w8_add_80_80");
        op(1'b1, 16'h0010, 16'h0020, 16'h00F0, 1'b0, 1'b0,   "w8_sub_10_20");

        // start held high: accepted every third cycle
        drive(1'b1, 1'b0, 16'h0001, 16'h0002);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_%0d",  i), r_busy,  ((i % 3) == 1) ? 1 : 0);
            check($sformatf("b2b_done_%0d",  i), r_done,  ((i % 3) == 2) ? 1 : 0);
            check($sformatf("b2b_ready_%0d", i), r_ready, ((i % 3) == 0) ? 1 : 0);
            if ((i % 3) == 2) check($sformatf("b2b_sum_%0d", i), r_sum, 16'h0003);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
